// File: rtl/settings_pkg.sv
// settings_pkg: shared kernel sizes, sample/accumulator types and the round/saturate helper.
package settings_pkg;
    localparam int DATA_SIZE   = 16;
    localparam int WINDOW_SIZE = 8;
    localparam int EXTRA_BITS  = 3;
    localparam int FULL_SIZE   = 2 * DATA_SIZE + EXTRA_BITS;

    typedef logic signed [DATA_SIZE-1:0] sample_t;
    typedef logic signed [FULL_SIZE-1:0] acc_t;

    typedef struct packed {
        sample_t value;
        logic    sat;
    } round_sat_t;

    function automatic round_sat_t round_sat(acc_t acc, int unsigned shift);
        logic signed [FULL_SIZE:0] rnd;
        logic signed [FULL_SIZE:0] ext;
        logic signed [FULL_SIZE:0] r;
        logic [FULL_SIZE-DATA_SIZE+1:0] hi;
        round_sat_t res;
        rnd = (shift != 0) ? ((FULL_SIZE + 1)'(1) << (shift - 1)) : '0;
        ext = {acc[FULL_SIZE-1], acc} + rnd;
        r = ext >>> shift;
        // the value fits when every bit above the output sign bit matches it
        hi = r[FULL_SIZE:DATA_SIZE-1];
        res.sat = !((&hi) | ~(|hi));
        res.value = res.sat ? (r[FULL_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}})
                            : r[DATA_SIZE-1:0];
        return res;
    endfunction
endpackage

// File: rtl/convol_sync_fifo.sv
// convol_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count.
module convol_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = wr_ptr_q == rd_ptr_q;
    assign pop       = rd_en_i & !empty_o;
    // a full FIFO still takes a write when a read frees the head slot on the same edge
    assign push      = wr_en_i & (!full_o | pop);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o   = count_q;

    always_comb count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + (AW + 1)'(push);
            rd_ptr_q <= rd_ptr_q + (AW + 1)'(pop);
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/convol_result_collector.sv
// convol_result_collector: drops warm-up results, rounds/saturates kernel output and buffers it
// onto a valid/ready stream with sticky saturation and overflow flags.
module convol_result_collector
    import settings_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int ROUND_SHIFT = 15,
    parameter int SKIP_COUNT  = WINDOW_SIZE - 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [FULL_SIZE-1:0]     in_data,
    input  logic                            in_valid,
    input  logic                            frame_start,
    input  logic                            clear_flags,
    output logic signed [DATA_SIZE-1:0]     out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level,
    output logic                            sat_flag,
    output logic                            overflow
);
    localparam int SW = $clog2(SKIP_COUNT + 2);

    logic [SW-1:0] skip_q, skip_d, skip_base;
    logic          warm, accept, xfer, full, empty;
    logic          s1_valid_q, s1_valid_d;
    sample_t       s1_data_q, s1_data_d, fifo_data;
    logic          sat_q, sat_d, ovf_q, ovf_d;
    round_sat_t    rs;

    always_comb begin
        skip_base  = frame_start ? '0 : skip_q;
        warm       = skip_base < SW'(SKIP_COUNT);
        accept     = in_valid & !warm;
        skip_d     = (in_valid & warm) ? skip_base + 1'b1 : skip_base;
        rs         = round_sat(in_data, ROUND_SHIFT);
        s1_valid_d = accept;
        s1_data_d  = rs.value;
        xfer       = out_valid & out_ready;
        // set beats clear when both happen in one cycle
        sat_d      = (accept & rs.sat) | (sat_q & !clear_flags);
        ovf_d      = (s1_valid_q & full & !xfer) | (ovf_q & !clear_flags);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skip_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            skip_q     <= skip_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    convol_sync_fifo #(
        .WIDTH(DATA_SIZE),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (s1_valid_q),
        .wr_data_i(s1_data_q),
        .rd_en_i  (out_ready),
        .rd_data_o(fifo_data),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (fill_level)
    );

    assign out_valid = !empty;
    assign out_data  = out_valid ? fifo_data : '0;
    assign sat_flag  = sat_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_convol_result_collector.sv
// tb_convol_result_collector: directed scoreboard bench for the result collector.
module tb_convol_result_collector;
    import settings_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [FULL_SIZE-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 frame_start = 1'b0;
    logic                 clear_flags = 1'b0;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [4:0]           fill_level;
    logic                 sat_flag;
    logic                 overflow;

    int checks = 0;
    int errors = 0;
    int outs = 0;
    int skip = 0;
    int base;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    convol_result_collector dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .frame_start(frame_start),
        .clear_flags(clear_flags),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .sat_flag   (sat_flag),
        .overflow   (overflow)
    );

    function automatic logic [15:0] model(longint x);
        longint r;
        r = (x + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(longint x, bit fs = 1'b0, bit drop = 1'b0, bit clr = 1'b0);
        in_data = x[FULL_SIZE-1:0];
        in_valid = 1'b1;
        frame_start = fs;
        clear_flags = clr;
        if (fs) skip = 0;
        if (skip < 7) skip++;
        else if (!drop) q.push_back(model(x));
        step();
        in_valid = 1'b0;
        frame_start = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        skip = 0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            outs++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_output observed=%0h expected=none", out_data);
            end else begin
                chk("out_data", out_data, q.pop_front());
            end
        end
    end

    initial begin
        idle(1);
        do_reset();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_fill", fill_level, 0);
        chk("reset_sat", sat_flag, 0);
        chk("reset_ovf", overflow, 0);

        out_ready = 1'b1;
        base = outs;
        for (int i = 0; i < 10; i++) send(32768);
        idle(4);
        chk("warmup_outs", outs - base, 3);

        send(16384);
        send(-16384);
        send(-16385);
        idle(3);
        chk("sat_before", sat_flag, 0);
        send(64'sd2147483648);
        idle(2);
        chk("sat_after4", sat_flag, 1);
        send(-64'sd2147483648);
        idle(3);
        chk("sat_sticky", sat_flag, 1);
        chk("drained2", q.size(), 0);

        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) send(longint'(i) * 32768, 1'b0, i > 16);
        idle(3);
        chk("full_fill", fill_level, 16);
        chk("full_ovf", overflow, 1);
        chk("full_valid", out_valid, 1);
        out_ready = 1'b1;
        idle(20);
        chk("drain_valid", out_valid, 0);
        chk("drain_q", q.size(), 0);

        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("clear_ovf", overflow, 0);
        chk("clear_sat", sat_flag, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(longint'(100 + i) * 32768);
        idle(2);
        chk("t4_fill", fill_level, 16);
        send(200 * 32768);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("t4_ovf", overflow, 0);
        chk("t4_fill_same", fill_level, 16);
        out_ready = 1'b1;
        idle(20);
        chk("t4_drained", out_valid, 0);
        chk("t4_q", q.size(), 0);

        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(longint'(i) * 32768);
        idle(2);
        chk("t5_fill", fill_level, 5);
        do_reset();
        chk("t5_valid", out_valid, 0);
        chk("t5_fill0", fill_level, 0);
        chk("t5_sat", sat_flag, 0);
        chk("t5_ovf", overflow, 0);
        out_ready = 1'b1;
        base = outs;
        for (int i = 0; i < 8; i++) send(longint'(300 + i) * 32768);
        idle(4);
        chk("t5_outs", outs - base, 1);

        base = outs;
        for (int i = 0; i < 3; i++) send(longint'(400 + i) * 32768);
        idle(3);
        for (int i = 0; i < 8; i++) send(longint'(500 + i) * 32768, i == 0);
        idle(4);
        chk("t6_outs", outs - base, 4);
        chk("t6_sat0", sat_flag, 0);
        send(64'sd2147483648);
        idle(1);
        chk("t6_sat1", sat_flag, 1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("t6_cleared", sat_flag, 0);
        send(-64'sd2147483648, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("t6_set_wins", sat_flag, 1);
        idle(5);
        chk("final_q", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
